mips_top: RTL and testbench
===========================

Name: mips_top

Overview:
- Top level of a multicycle 32-bit MIPS subset processor, paired with one unified word-addressed instruction/data memory.
- Fetches and executes a program preloaded into memory.
- Drives a 16-bit LED register through a memory-mapped store.
- Sits at the FPGA top; the only inputs are board clock and reset.

Parameters:
- MEM_WORDS, 512, depth of unified memory in 32-bit words.
- LED_ADDR, 32'h504, byte address of the memory-mapped LED register (word 321).
- RESET_PC, 32'h0, program counter value after reset.

Ports:
- i_clk  input  1  system clock; all state updates on rising edge.
- i_rst  input  1  synchronous, active-high reset.
- o_leds  output  16  LED register contents.

Behaviour:
- Reset (i_rst high at a rising edge):
  - PC=RESET_PC, FSM=FETCH, o_leds=16'h0, IR and internal registers cleared.
  - Memory contents are not cleared; no memory write occurs in a reset cycle.
  - Reset mid-instruction abandons that instruction.
- Memory:
  - Word index = addr[10:2]; upper bits ignored, so addresses wrap modulo MEM_WORDS.
  - Combinational read; write on rising edge when memwrite=1.
- Register file: 32x32, two combinational reads, write on rising edge; $0 reads 0, writes to $0 are ignored.
- Instruction set:
  - R-type (funct): add 0x20, sub 0x22, and 0x24, or 0x25, slt 0x2A.
  - I-type (op): lw 0x23, sw 0x2B, beq 0x04, addi 0x08.
  - J-type (op): j 0x02.
  - Arithmetic is two's-complement 32-bit, wrap-around, no overflow traps.
  - slt is signed compare.
- FSM states and transitions:
  - FETCH: IR<=mem[PC]; PC<=PC+4.
  - DECODE: read rs/rt; ALUOut<=PC+(signext(imm)<<2). Next state by opcode:
    - lw/sw -> MEMADR
    - R -> EXECUTE
    - beq -> BRANCH
    - addi -> ADDIEX
    - j -> JUMP
    - any other opcode -> FETCH (executes as a NOP)
  - MEMADR: ALUOut<=rs+signext(imm); -> MEMRD (lw) / MEMWR (sw).
  - MEMRD -> MEMWB: rt<=data.
  - MEMWR: mem[ALUOut]<=rt.
  - EXECUTE -> ALUWB: rd<=result.
  - ADDIEX -> ADDIWB: rt<=result.
  - BRANCH: if rs==rt then PC<=ALUOut.
  - JUMP: PC<={PC[31:28],addr26,2'b00}.
  - Every terminal state returns to FETCH.
- Cycles per instruction: lw 5; sw, R, addi 4; beq, j 3; unknown opcode 2.
- LED register:
  - sw with ALUOut==LED_ADDR updates o_leds<=rt[15:0] on the same edge as the memory write.
  - That memory word is also written.
  - o_leds changes only on such a store or on reset.
- Completion convention: programs signal completion by storing 1 to byte 0x500 (word 320); the hardware treats that word as ordinary memory.

Decomposition:
- Package mips_pkg holds:
  - opcode and funct constants
  - FSM state enum
  - ALU control enum (ADD, SUB, AND, OR, SLT)
- Memory sub-module mips_mem:
  - Instantiated in mips_top with instance name mem.
  - Wraps the storage instance u_mem, whose array is named mem.
  - Benches preload it hierarchically via $readmemh on <dut>.mem.u_mem.mem and poll word 320.
- Controller FSM, ALU and register file may be inline or in small sub-modules.

Test Plan:
- Store to LED register: addi $2,$0,0x1460; sw $2,0x504($0); addi $3,$0,1; sw $3,0x500($0); loop j. Required: o_leds==16'h1460, mem[321]==32'h1460, mem[320]==1 within 20000 cycles.
- Arithmetic: $1=7, $2=5 via addi; add/sub/and/or/slt chain, results stored to 0x504. Required: o_leds matches 12, 2, 5, 7, 0 (and slt $2,$1 gives 1) in sequence.
- Load/store: sw 0xDEADBEEF-pattern word to 0x400, lw back, store to 0x504. Required: o_leds==16'hBEEF; lw takes exactly 5 cycles FETCH..MEMWB.
- Control flow: beq taken skips one store, beq not-taken falls through, j to an absolute target. Required: o_leds shows only the expected store value; PC sequence is correct.
- Reset: assert i_rst mid-sw to 0x504 (in MEMADR). Required: o_leds==0, PC==0, no memory write; after release the program reruns and reaches the same final o_leds.
- Edge cases:
  - Writes to $0 leave $0==0.
  - Unknown opcode acts as a NOP and execution continues.
  - Address 0x800+0x504 aliases to LED_ADDR.

Source files
------------

// File: rtl/mips_pkg.sv
// mips_pkg: opcode/funct encodings, controller states and ALU operations for the multicycle MIPS core.
package mips_pkg;
   localparam logic [5:0] OP_R = 6'h00, OP_J = 6'h02, OP_BEQ = 6'h04, OP_ADDI = 6'h08, OP_LW = 6'h23, OP_SW = 6'h2B;
   localparam logic [5:0] F_ADD = 6'h20, F_SUB = 6'h22, F_AND = 6'h24, F_OR = 6'h25, F_SLT = 6'h2A;
   typedef enum logic [3:0] {
      S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
      S_EXECUTE, S_ALUWB, S_ADDIEX, S_ADDIWB, S_BRANCH, S_JUMP
   } state_e;
   typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT} alu_e;
   // Unrecognised funct codes fall back to add.
   function automatic alu_e alu_ctl(input logic [5:0] funct);
      return funct == F_ADD ? ALU_ADD : funct == F_SUB ? ALU_SUB : funct == F_AND ? ALU_AND :
             funct == F_OR ? ALU_OR : funct == F_SLT ? ALU_SLT : ALU_ADD;
   endfunction
   function automatic logic [31:0] alu(input alu_e c, input logic [31:0] a, input logic [31:0] b);
      return c == ALU_SUB ? a - b : c == ALU_AND ? a & b : c == ALU_OR ? a | b :
             c == ALU_SLT ? {31'b0, $signed(a) < $signed(b)} : a + b;
   endfunction
endpackage

// File: rtl/mips_mem.sv
// mips_mem: unified word-addressed instruction/data memory; combinational read, clocked write.
module mips_ram #(parameter int MEM_WORDS = 512) (
   input  logic                         clk,
   input  logic                         we,
   input  logic [$clog2(MEM_WORDS)-1:0] idx,
   input  logic [31:0]                  wd,
   output logic [31:0]                  rd
);
   logic [31:0] mem [MEM_WORDS];
   assign rd = mem[idx];
   always_ff @(posedge clk)
      if (we) mem[idx] <= wd;
endmodule

module mips_mem import mips_pkg::*; #(parameter int MEM_WORDS = 512) (
   input  logic        clk,
   input  logic        we,
   input  logic [31:0] addr,
   input  logic [31:0] wd,
   output logic [31:0] rd
);
   localparam int AW = $clog2(MEM_WORDS);
   // Byte offset and bits above the array depth are dropped, so addresses wrap.
   logic unused;
   assign unused = &{1'b0, addr[31:AW+2], addr[1:0]};
   mips_ram #(.MEM_WORDS(MEM_WORDS)) u_mem (.clk(clk), .we(we), .idx(addr[AW+1:2]), .wd(wd), .rd(rd));
endmodule

// File: rtl/mips_top.sv
// mips_top: multicycle MIPS subset core with unified memory and a memory-mapped LED register.
module mips_top import mips_pkg::*; #(
   parameter int          MEM_WORDS = 512,
   parameter logic [31:0] LED_ADDR  = 32'h504,
   parameter logic [31:0] RESET_PC  = 32'h0
) (
   input  logic        i_clk,
   input  logic        i_rst,
   output logic [15:0] o_leds
);
   localparam int AW = $clog2(MEM_WORDS);
   state_e      state;
   logic [31:0] pc, ir, aluout, mdr, maddr, mrd, ra, rb, simm;
   logic [31:0] rf [32];
   logic [5:0]  op;
   logic [4:0]  rs, rt, rd;
   logic        memwrite;
   assign op = ir[31:26];
   assign rs = ir[25:21];
   assign rt = ir[20:16];
   assign rd = ir[15:11];
   assign simm = {{16{ir[15]}}, ir[15:0]};
   assign ra = rs == 5'd0 ? 32'h0 : rf[rs];
   assign rb = rt == 5'd0 ? 32'h0 : rf[rt];
   assign maddr = state == S_FETCH ? pc : aluout;
   assign memwrite = state == S_MEMWR && !i_rst;
   mips_mem #(.MEM_WORDS(MEM_WORDS)) mem (.clk(i_clk), .we(memwrite), .addr(maddr), .wd(rb), .rd(mrd));
   always_ff @(posedge i_clk)
      if (i_rst) begin
         state <= S_FETCH;
         pc <= RESET_PC;
         ir <= '0;
         aluout <= '0;
         mdr <= '0;
         o_leds <= '0;
         for (int i = 0; i < 32; i++) rf[i] <= '0;
      end else begin
         state <= S_FETCH;
         case (state)
            S_FETCH: begin
               ir <= mrd;
               pc <= pc + 32'd4;
               state <= S_DECODE;
            end
            S_DECODE: begin
               aluout <= pc + {simm[29:0], 2'b00};
               state <= op == OP_LW || op == OP_SW ? S_MEMADR : op == OP_R ? S_EXECUTE :
                        op == OP_BEQ ? S_BRANCH : op == OP_ADDI ? S_ADDIEX : op == OP_J ? S_JUMP : S_FETCH;
            end
            S_MEMADR: begin
               aluout <= ra + simm;
               state <= op == OP_LW ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
               mdr <= mrd;
               state <= S_MEMWB;
            end
            S_MEMWB: if (rt != 5'd0) rf[rt] <= mdr;
            // LED match uses the wrapped word index so aliased addresses hit it too.
            S_MEMWR: if (aluout[AW+1:2] == LED_ADDR[AW+1:2]) o_leds <= rb[15:0];
            S_EXECUTE: begin
               aluout <= alu(alu_ctl(ir[5:0]), ra, rb);
               state <= S_ALUWB;
            end
            S_ALUWB: if (rd != 5'd0) rf[rd] <= aluout;
            S_ADDIEX: begin
               aluout <= ra + simm;
               state <= S_ADDIWB;
            end
            S_ADDIWB: if (rt != 5'd0) rf[rt] <= aluout;
            S_BRANCH: if (ra == rb) pc <= aluout;
            S_JUMP: pc <= {pc[31:28], ir[25:0], 2'b00};
            default: state <= S_FETCH;
         endcase
      end
endmodule

// File: tb/tb_mips_top.sv
// tb_mips_top: directed programs; LED updates are checked against a queue of expected value/cycle pairs.
module tb_mips_top;
   logic        i_clk = 0;
   logic        i_rst = 1;
   logic [15:0] o_leds;
   int          tests = 0, fails = 0, cyc = 0;
   logic [31:0] prog [$];
   typedef struct {logic [15:0] v; int c;} exp_t;
   exp_t        q [$];

   mips_top dut (.i_clk(i_clk), .i_rst(i_rst), .o_leds(o_leds));

   always #5 i_clk = ~i_clk;

   initial forever begin
      @(posedge i_clk);
      cyc = i_rst ? 0 : cyc + 1;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] ri(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt, input logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction
   function automatic logic [31:0] rr(input logic [5:0] f, input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
      return {6'h00, rs, rt, rd, 5'h00, f};
   endfunction
   function automatic logic [31:0] jj(input logic [25:0] w);
      return {6'h02, w};
   endfunction

   task automatic p(input logic [31:0] w);
      prog.push_back(w);
   endtask
   task automatic expect_led(input logic [15:0] v, input int c);
      exp_t e;
      e.v = v;
      e.c = c;
      q.push_back(e);
   endtask

   // Monitor: every LED change outside reset consumes one scoreboard entry.
   initial begin
      logic [15:0] prev;
      exp_t e;
      prev = 0;
      forever begin
         @(negedge i_clk);
         if (i_rst) prev = o_leds;
         else if (o_leds !== prev) begin
            prev = o_leds;
            if (q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_led: got %h expected no update", o_leds);
            end else begin
               e = q.pop_front();
               chk("led_value", {16'h0, o_leds}, {16'h0, e.v});
               if (e.c >= 0) chk("led_cycle", cyc, e.c);
            end
         end
      end
   end

   task automatic load();
      i_rst = 1;
      repeat (2) @(posedge i_clk);
      for (int k = 0; k < 512; k++) dut.mem.u_mem.mem[k] <= 32'h0;
      for (int k = 0; k < prog.size(); k++) dut.mem.u_mem.mem[k] <= prog[k];
      @(posedge i_clk);
      prog.delete();
   endtask

   task automatic go(input string name);
      int n = 0;
      @(negedge i_clk);
      i_rst = 0;
      while (dut.mem.u_mem.mem[320] !== 32'h1 && n < 2000) begin
         @(negedge i_clk);
         n++;
      end
      chk({name, "_done"}, dut.mem.u_mem.mem[320], 32'h1);
      repeat (3) @(negedge i_clk);
      chk({name, "_pending"}, q.size(), 0);
   endtask

   task automatic prog_led();
      p(ri(6'h08, 0, 2, 16'h1460));
      p(ri(6'h2B, 0, 2, 16'h0504));
      p(ri(6'h08, 0, 3, 16'h0001));
      p(ri(6'h2B, 0, 3, 16'h0500));
      p(jj(26'd4));
   endtask

   initial begin
      int n;
      #1;
      // LED store
      prog_led();
      load();
      chk("reset_leds", {16'h0, o_leds}, 32'h0);
      chk("reset_pc", dut.pc, 32'h0);
      expect_led(16'h1460, 8);
      go("led");
      chk("led_mem321", dut.mem.u_mem.mem[321], 32'h1460);

      // Arithmetic, $0 writes, unknown opcode, aliased LED address
      p(ri(6'h08, 0, 1, 16'd7));
      p(ri(6'h08, 0, 2, 16'd5));
      p(rr(6'h20, 1, 2, 3)); p(ri(6'h2B, 0, 3, 16'h0504));
      p(rr(6'h22, 1, 2, 3)); p(ri(6'h2B, 0, 3, 16'h0504));
      p(rr(6'h24, 1, 2, 3)); p(ri(6'h2B, 0, 3, 16'h0504));
      p(rr(6'h25, 1, 2, 3)); p(ri(6'h2B, 0, 3, 16'h0504));
      p(rr(6'h2A, 1, 2, 3)); p(ri(6'h2B, 0, 3, 16'h0504));
      p(rr(6'h2A, 2, 1, 3)); p(ri(6'h2B, 0, 3, 16'h0504));
      p(ri(6'h08, 0, 0, 16'd5)); p(ri(6'h2B, 0, 0, 16'h0504));
      p(32'hFC00_0000);
      p(ri(6'h08, 0, 4, 16'h0077)); p(ri(6'h2B, 0, 4, 16'h0504));
      p(ri(6'h08, 0, 5, 16'h0055)); p(ri(6'h2B, 0, 5, 16'h0D04));
      p(ri(6'h08, 0, 6, 16'h0001)); p(ri(6'h2B, 0, 6, 16'h0500));
      p(jj(26'd26));
      load();
      expect_led(16'd12, 16); expect_led(16'd2, 24); expect_led(16'd5, 32);
      expect_led(16'd7, 40); expect_led(16'd0, 48); expect_led(16'd1, 56);
      expect_led(16'd0, 64); expect_led(16'h77, 74); expect_led(16'h55, 82);
      go("arith");
      chk("alias_mem321", dut.mem.u_mem.mem[321], 32'h55);

      // Load/store round trip
      p(ri(6'h23, 0, 1, 16'h0600));
      p(ri(6'h2B, 0, 1, 16'h0400));
      p(ri(6'h23, 0, 2, 16'h0400));
      p(ri(6'h2B, 0, 2, 16'h0504));
      p(ri(6'h08, 0, 3, 16'h0001));
      p(ri(6'h2B, 0, 3, 16'h0500));
      p(jj(26'd6));
      load();
      dut.mem.u_mem.mem[384] <= 32'hDEAD_BEEF;
      expect_led(16'hBEEF, 18);
      go("ldst");
      chk("ldst_mem256", dut.mem.u_mem.mem[256], 32'hDEAD_BEEF);
      chk("ldst_mem321", dut.mem.u_mem.mem[321], 32'hDEAD_BEEF);

      // Control flow
      p(ri(6'h08, 0, 1, 16'd3));
      p(ri(6'h08, 0, 2, 16'd3));
      p(ri(6'h04, 1, 2, 16'd1));
      p(ri(6'h2B, 0, 1, 16'h0504));
      p(ri(6'h08, 0, 3, 16'h000A));
      p(ri(6'h04, 1, 3, 16'd1));
      p(ri(6'h2B, 0, 3, 16'h0504));
      p(jj(26'd10));
      p(ri(6'h08, 0, 4, 16'h0099));
      p(ri(6'h2B, 0, 4, 16'h0504));
      p(ri(6'h08, 0, 5, 16'h005C));
      p(ri(6'h2B, 0, 5, 16'h0504));
      p(ri(6'h08, 0, 6, 16'h0001));
      p(ri(6'h2B, 0, 6, 16'h0500));
      p(jj(26'd14));
      load();
      expect_led(16'h000A, 22);
      expect_led(16'h005C, 33);
      go("ctrl");

      // Reset while the LED store sits in MEMADR
      prog_led();
      load();
      @(negedge i_clk);
      i_rst = 0;
      n = 0;
      while (cyc != 6 && n < 100) begin
         @(negedge i_clk);
         n++;
      end
      chk("rst_reach_memadr", cyc, 6);
      i_rst = 1;
      repeat (2) @(posedge i_clk);
      @(negedge i_clk);
      chk("rst_leds", {16'h0, o_leds}, 32'h0);
      chk("rst_pc", dut.pc, 32'h0);
      chk("rst_no_write", dut.mem.u_mem.mem[321], 32'h0);
      expect_led(16'h1460, 8);
      go("rerun");
      chk("rerun_mem321", dut.mem.u_mem.mem[321], 32'h1460);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end
endmodule
